// File: rtl/bram_frame_reader.sv
// bram_frame_reader: streams one frame of bytes out of a BRAM ring buffer through a
// credit-managed skid FIFO onto a valid/ready byte stream.
module bram_frame_reader #(
    parameter int ADDR_W     = 12,
    parameter int READ_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] frame_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_dout,
    output logic [7:0]        m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] issue_cnt, rem;
    logic [READ_LAT-1:0] pipe;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_cnt;
    logic              accept, issue, push, pop;
    int                used;

    assign accept  = state == IDLE && start;
    assign push    = pipe[READ_LAT-1];
    assign pop     = m_valid && m_ready;
    assign m_valid = fifo_cnt != '0;
    assign m_data  = m_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign m_last  = m_valid && rem == ADDR_W'(1);
    assign busy    = state == READ || state == DRAIN;
    assign done    = state == DONE;

    // Reads in flight plus queued bytes must always fit in the FIFO once they land.
    always_comb begin
        used     = $countones(pipe) + int'(fifo_cnt) - int'(pop) + 1;
        issue    = state == READ && issue_cnt != '0 && used <= FIFO_DEPTH;
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = frame_len == '0 ? DONE : READ;
            READ:    if (issue_cnt == '0) state_nx = DRAIN;
            DRAIN:   if (rem == '0 || (rem == ADDR_W'(1) && pop)) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Latching start_addr is itself the first read; issue_cnt counts the reads still to go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ram_addr  <= '0;
            issue_cnt <= '0;
            rem       <= '0;
            pipe      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                ram_addr  <= start_addr;
                issue_cnt <= frame_len == '0 ? '0 : frame_len - 1'b1;
                rem       <= frame_len;
            end else begin
                if (issue) begin
                    ram_addr  <= ram_addr + 1'b1;
                    issue_cnt <= issue_cnt - 1'b1;
                end
                if (pop) rem <= rem - 1'b1;
            end
            pipe <= READ_LAT'({pipe, issue || (accept && frame_len != '0)});
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= ram_dout;
    end
endmodule

// File: tb/tb_bram_frame_reader.sv
// tb_bram_frame_reader: table-driven and randomized frames checked against a queue
// model of the ring buffer contents, plus reset/re-start corner sequences.
module tb_bram_frame_reader;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, m_ready = 1'b0;
    logic [11:0] start_addr = '0, frame_len = '0, ram_addr;
    logic [7:0]  ram_dout, m_data;
    logic        busy, done, m_valid, m_last;

    always #5 clk = ~clk;

    bram_frame_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .frame_len(frame_len), .busy(busy), .done(done), .ram_addr(ram_addr),
        .ram_dout(ram_dout), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready)
    );

    // BRAM: ram_addr is the address stage, this register is the OUTREG.
    logic [7:0] ram [4096];
    always @(posedge clk) ram_dout <= ram[ram_addr];

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string nm, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    logic [7:0]  exp_q[$];
    logic [11:0] addr_q[$];
    logic [7:0]  e_b, first_b, last_b, pd;
    int first_v, last_pop, done_cyc, n_done, n_beats, c0;
    bit busy_seen, in_frame = 0, pv = 0, pr = 0, pl = 0;
    int rmode = 0, stall_at = -100, rs = 0;

    // 0: always ready, 1: random with stalls, 2: never ready
    initial forever begin
        @(posedge clk); #1;
        if (rmode == 0) m_ready = 1'b1;
        else if (rmode == 2) m_ready = 1'b0;
        else if (cyc >= stall_at && cyc < stall_at + 20) m_ready = 1'b0;
        else if (rs > 0) begin rs--; m_ready = 1'b0; end
        else if ($urandom_range(0, 31) == 0) begin rs = $urandom_range(5, 20); m_ready = 1'b0; end
        else m_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && exp_q.size() == 0) check(0, "stale_valid", int'(m_data), 0);
            if (m_valid && first_v < 0) first_v = cyc;
            if (m_valid && m_ready && exp_q.size() != 0) begin
                e_b = exp_q.pop_front();
                check(m_data == e_b, "data", int'(m_data), int'(e_b));
                check(m_last == (exp_q.size() == 0), "last", int'(m_last), int'(exp_q.size() == 0));
                if (n_beats == 0) first_b = m_data;
                last_b = m_data;
                n_beats++;
                last_pop = cyc;
            end
            if (pv && !pr)
                check(m_valid && m_data == pd && m_last == pl, "stall_hold", int'(m_data), int'(pd));
            check(dut.fifo_cnt <= 4, "fifo_bound", int'(dut.fifo_cnt), 4);
            if (done) begin done_cyc = cyc; n_done++; end
            if (busy) busy_seen = 1;
            if (in_frame && cyc > c0 && (addr_q.size() == 0 || addr_q[$] != ram_addr))
                addr_q.push_back(ram_addr);
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
        end else pv = 0;
    end

    task automatic run_frame(input logic [11:0] a, input logic [11:0] n, input int mode, input bit rp);
        bit ok;
        exp_q.delete();
        addr_q.delete();
        for (int k = 0; k < int'(n); k++) exp_q.push_back(ram[12'(a + k)]);
        first_v = -1; last_pop = -1; done_cyc = -1; n_done = 0; n_beats = 0; busy_seen = 0;
        rmode = mode;
        @(posedge clk); #1;
        c0 = cyc;
        stall_at = mode == 1 ? c0 + 6 : -100;
        start = 1'b1; start_addr = a; frame_len = n; in_frame = 1;
        @(posedge clk); #1;
        start = 1'b0; start_addr = 12'($urandom); frame_len = 12'($urandom);
        if (rp) begin
            @(posedge clk); #1; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
        end
        for (int t = 0; t < 3000 && n_done == 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1 in_frame = 0;
        check(n_done == 1, "done_pulses", n_done, 1);
        check(n_beats == int'(n), "beats", n_beats, int'(n));
        check(busy_seen == (n != 0), "busy_seen", int'(busy_seen), int'(n != 0));
        if (n == 0) begin
            check(done_cyc == c0 + 1, "done_lat_len0", done_cyc - c0, 1);
            check(first_v < 0, "no_valid_len0", first_v, -1);
        end else begin
            ok = addr_q.size() == int'(n);
            for (int k = 0; k < addr_q.size(); k++) if (addr_q[k] != 12'(a + k)) ok = 0;
            check(ok, "addr_seq", addr_q.size(), int'(n));
            check(done_cyc == last_pop + 1, "done_after_last", done_cyc - last_pop, 1);
            if (mode == 0) begin
                check(first_v - c0 == 3, "latency", first_v - c0, 3);
                check(last_pop - first_v == int'(n) - 1, "throughput", last_pop - first_v, int'(n) - 1);
            end
        end
    endtask

    task automatic check_reset_outs();
        check(ram_addr == 0, "rst_ram_addr", int'(ram_addr), 0);
        check(!m_valid, "rst_m_valid", int'(m_valid), 0);
        check(!m_last, "rst_m_last", int'(m_last), 0);
        check(m_data == 0, "rst_m_data", int'(m_data), 0);
        check(!busy, "rst_busy", int'(busy), 0);
        check(!done, "rst_done", int'(done), 0);
    endtask

    typedef struct {
        logic [11:0] a;
        logic [11:0] n;
        int          mode;
        bit          rp;
        logic [7:0]  f;
        logic [7:0]  l;
    } vec_t;
    vec_t tbl[7];

    initial begin
        tbl[0] = '{12'h010, 12'd5,  0, 1'b0, 8'h10, 8'h14};
        tbl[1] = '{12'hFFE, 12'd4,  0, 1'b0, 8'hFE, 8'h01};
        tbl[2] = '{12'h100, 12'd16, 1, 1'b1, 8'h00, 8'h0F};
        tbl[3] = '{12'h000, 12'd1,  0, 1'b0, 8'h00, 8'h00};
        tbl[4] = '{12'hFFF, 12'd3,  1, 1'b0, 8'hFF, 8'h01};
        tbl[5] = '{12'h7F0, 12'd40, 1, 1'b0, 8'hF0, 8'h17};
        tbl[6] = '{12'h020, 12'd0,  0, 1'b0, 8'h00, 8'h00};
        for (int i = 0; i < 4096; i++) ram[i] = 8'(i);

        repeat (3) @(posedge clk);
        #1 check_reset_outs();
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_frame(tbl[i].a, tbl[i].n, tbl[i].mode, tbl[i].rp);
            if (tbl[i].n != 0) begin
                check(first_b == tbl[i].f, "tbl_first", int'(first_b), int'(tbl[i].f));
                check(last_b == tbl[i].l, "tbl_last", int'(last_b), int'(tbl[i].l));
            end
        end

        // Ignored re-start, then reset in DRAIN with two bytes queued.
        exp_q.delete();
        exp_q.push_back(ram[12'h200]);
        exp_q.push_back(ram[12'h201]);
        first_v = -1; n_beats = 0; rmode = 2;
        @(posedge clk); #1 start = 1'b1; start_addr = 12'h200; frame_len = 12'd2;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1; start_addr = 12'h300; frame_len = 12'd7;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(m_valid && m_data == ram[12'h200], "drain_head", int'(m_data), int'(ram[12'h200]));
        check(dut.fifo_cnt == 2, "drain_queued", int'(dut.fifo_cnt), 2);
        check(busy, "drain_busy", int'(busy), 1);
        check(ram_addr == 12'h201, "restart_ignored", int'(ram_addr), 12'h201);
        #2 rst_n = 1'b0;
        #1 check_reset_outs();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        rmode = 0;
        repeat (8) @(posedge clk);
        #1 check(!m_valid, "no_stale_after_rst", int'(m_valid), 0);
        run_frame(12'h123, 12'd7, 0, 1'b0);

        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 10; i++)
            run_frame(12'($urandom), 12'($urandom_range(0, 50)), $urandom_range(0, 1), 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
